debouncer_multi: RTL and testbench

- Parametrised N-channel successor to the single-channel delayed debouncer.
- Each channel has its own:
  - input synchroniser;
  - 4-state accept-after-stable FSM;
  - stability counter.
- Emits a debounced level per channel plus registered one-cycle rise and fall ticks, so downstream FSMs need no separate edge detector.
- Sits between raw board buttons/switches and application FSMs.

---
 rtl/debouncer_multi.sv | 126 ++++++++++++
 tb/tb_debouncer_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// N-channel debouncer: per-channel synchroniser, accept-after-stable FSM and stability counter.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from first sample to debounced; no backpressure (level outputs, one-cycle ticks).
module debouncer_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter bit INIT_LEVEL      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } state_t;

    localparam state_t RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q;
        state_t                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   deb_q;
        logic                   deb_d;
        logic                   rise_q;
        logic                   fall_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= RESET_STATE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Any return to the old level while waiting restarts acceptance from zero.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RESET_STATE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Level and ticks are registered from the next-state decode so they
        // change on the same edge as the state and never glitch.
        assign deb_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                deb_q  <= INIT_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                deb_q  <= deb_d;
                rise_q <= deb_d & ~deb_q;
                fall_q <= ~deb_d & deb_q;
            end
        end

        assign debounced[i] = deb_q;
        assign rise_tick[i] = rise_q;
        assign fall_tick[i] = fall_q;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: two builds (INIT_LEVEL 0 and 1) share stimulus;
// a run-length model of the sampled input predicts every cycle's outputs.
module tb_debouncer_multi;

    localparam int CH = 4;
    localparam int DC = 8;
    localparam int SS = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [CH-1:0] noisy = '1;

    logic [CH-1:0] deb0, rise0, fall0;
    logic [CH-1:0] deb1, rise1, fall1;

    always #5 clk = ~clk;

    debouncer_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)
    ) u_dut0 (
        .clk(clk), .reset(rst), .noisy(noisy),
        .debounced(deb0), .rise_tick(rise0), .fall_tick(fall0)
    );

    debouncer_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .INIT_LEVEL(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(rst), .noisy(noisy),
        .debounced(deb1), .rise_tick(rise1), .fall_tick(fall1)
    );

    typedef struct packed {
        logic [CH-1:0] d0, r0, f0, d1, r1, f1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: per build and channel, the level the FSM sees is the input sampled
    // SS edges earlier; the output adopts a new level once that sampled level has
    // differed from the output for DC+1 consecutive edges.
    bit m_deb[2][CH];
    int m_run[2][CH];
    bit m_hist[2][CH][$];

    task automatic cmp(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", nm, $time, got, want);
        end
    endtask

    task automatic model_step(input logic [CH-1:0] n, input logic r);
        exp_t          e;
        bit            s;
        bit            init;
        logic [CH-1:0] d [2];
        logic [CH-1:0] rs[2];
        logic [CH-1:0] fl[2];
        for (int b = 0; b < 2; b++) begin
            init  = (b == 1);
            rs[b] = '0;
            fl[b] = '0;
            for (int c = 0; c < CH; c++) begin
                if (r) begin
                    m_deb[b][c] = init;
                    m_run[b][c] = 0;
                    m_hist[b][c].delete();
                    for (int k = 0; k < SS; k++) m_hist[b][c].push_back(init);
                end else begin
                    s = m_hist[b][c].pop_front();
                    m_hist[b][c].push_back(n[c]);
                    if (s != m_deb[b][c]) begin
                        m_run[b][c]++;
                        if (m_run[b][c] == DC + 1) begin
                            m_deb[b][c] = s;
                            m_run[b][c] = 0;
                            if (s) rs[b][c] = 1'b1;
                            else   fl[b][c] = 1'b1;
                        end
                    end else begin
                        m_run[b][c] = 0;
                    end
                end
                d[b][c] = m_deb[b][c];
            end
        end
        e.d0 = d[0]; e.r0 = rs[0]; e.f0 = fl[0];
        e.d1 = d[1]; e.r1 = rs[1]; e.f1 = fl[1];
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic cyc(input logic [CH-1:0] n, input logic r);
        @(negedge clk);
        noisy = n;
        rst   = r;
        model_step(n, r);
        if (r) begin
            #1;
            cmp("async_reset_deb0", deb0, '0);
            cmp("async_reset_deb1", deb1, '1);
            cmp("async_reset_ticks", rise0 | fall0 | rise1 | fall1, '0);
        end
    endtask

    task automatic hold(input logic [CH-1:0] n, input int k);
        repeat (k) cyc(n, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("deb0", deb0, e.d0);
                cmp("rise0", rise0, e.r0);
                cmp("fall0", fall0, e.f0);
                cmp("deb1", deb1, e.d1);
                cmp("rise1", rise1, e.r1);
                cmp("fall1", fall1, e.f1);
            end
        end
    end

    initial begin : stimulus
        logic [CH-1:0] n;
        int            p;

        // Reset with inputs high, then release with inputs low.
        repeat (3) cyc(4'b1111, 1'b1);
        hold(4'b0000, 16);

        // Clean rise and fall on ch0.
        hold(4'b0001, 20);
        hold(4'b0000, 20);

        // Bounce train on ch1, then short and long pulses.
        repeat (5) begin
            hold(4'b0010, 3);
            hold(4'b0000, 2);
        end
        hold(4'b0000, 15);
        hold(4'b0010, DC - 1);
        hold(4'b0000, 15);
        hold(4'b0010, DC + 1);
        hold(4'b0000, 20);

        // ch2 and ch3 together, then ch2 bounces while ch3 holds.
        hold(4'b1100, 16);
        repeat (3) begin
            hold(4'b1000, 3);
            hold(4'b1100, 2);
        end
        hold(4'b1000, 20);
        hold(4'b0000, 20);

        // Reset while ch0 is part-way through acceptance.
        hold(4'b0001, 8);
        cyc(4'b0001, 1'b1);
        hold(4'b0001, 16);
        hold(4'b0000, 16);

        // Random inputs with varying bounce rates and rare resets.
        n = '0;
        p = 10;
        for (int t = 0; t < 2000; t++) begin
            if (t % 100 == 0) p = $urandom_range(0, 2) == 0 ? 3 : ($urandom_range(0, 1) == 0 ? 10 : 30);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, p - 1) == 0) n[c] = ~n[c];
            cyc(n, $urandom_range(0, 299) == 0);
        end
        hold(n, 12);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
